miriscv_lsu: RTL and testbench

Load/store unit sitting between the decoder/ALU and the register file write-back path. It accepts one load or store request per instruction and runs it on the data-memory bus with a req/ack handshake. It stalls the core until the bus acknowledges. It returns byte/half/word load data, sign- or zero-extended, as the register file write data, plus a one-cycle write-enable pulse.

---
 rtl/miriscv_pkg.sv | 33 +++
 rtl/miriscv_lsu_ext.sv | 35 +++
 rtl/miriscv_lsu.sv | 154 +++++++++++++++
 tb/tb_miriscv_lsu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// rtl/miriscv_pkg.sv - shared load/store size codes, LSU state encoding and legality helper
//
// Purpose: definitions shared by the load/store unit and its load-extraction helper.
// Contents: LDST_* size codes, lsu_state_e, ldst_misaligned().

package miriscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Unknown size codes are reported through the same path as misaligned
    // addresses so the core sees a single "cannot perform" indication.
    function automatic logic ldst_misaligned(input logic [2:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            LDST_B, LDST_BU: bad = 1'b0;
            LDST_H, LDST_HU: bad = offset[0];
            LDST_W:          bad = (offset != 2'b00);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/miriscv_lsu_ext.sv
// rtl/miriscv_lsu_ext.sv - combinational load-data lane extraction and extension
//
// Purpose: pick the addressed byte/half out of a bus word and sign- or zero-extend it.
// Ports:
//   rdata  in  32  bus read word
//   size   in  3   LDST_* size code
//   offset in  2   byte offset of the access within the word
//   result out 32  extended load value

module miriscv_lsu_ext
    import miriscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[8*offset +: 8];
        // Halfword accesses are 2-byte aligned, so only offset[1] selects the lane.
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LDST_B:  result = {{24{byte_lane[7]}}, byte_lane};
            LDST_BU: result = {24'b0, byte_lane};
            LDST_H:  result = {{16{half_lane[15]}}, half_lane};
            LDST_HU: result = {16'b0, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// rtl/miriscv_lsu.sv - load/store unit: request FSM, byte enables, store lanes, load write-back
//
// Purpose: run one load/store per instruction on the req/ack data bus, stalling the core
// until the bus acknowledges, and return extended load data with a one-cycle valid pulse.
// Ports:
//   clk_i, reset (sync, active-high)
//   lsu_req_i/we_i/size_i/addr_i/data_i  core request (held while stalled)
//   lsu_stall_req_o, lsu_misalign_o      combinational core feedback
//   lsu_data_o, lsu_valid_o              register-file write-back
//   data_req_o/we_o/be_o/addr_o/wdata_o  data bus request (registered)
//   data_rdata_i, data_ack_i             data bus response

module miriscv_lsu
    import miriscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_valid_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_ack_i
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic        accept;
    logic        ack_seen;
    logic        misalign;
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] ext_result;

    assign misalign = ldst_misaligned(lsu_size_i, lsu_addr_i[1:0]);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        ack_seen        = 1'b0;
        lsu_stall_req_o = 1'b0;
        lsu_misalign_o  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    if (misalign) begin
                        lsu_misalign_o = 1'b1;
                    end else begin
                        lsu_stall_req_o = 1'b1;
                        accept          = 1'b1;
                        state_d         = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                lsu_stall_req_o = 1'b1;
                if (data_ack_i) begin
                    ack_seen = 1'b1;
                    state_d  = LSU_DONE;
                end
            end
            // Stall drops here so the core retires; a new request is only
            // looked at once we are back in IDLE.
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
        if (reset) begin
            lsu_stall_req_o = 1'b0;
            lsu_misalign_o  = 1'b0;
        end
    end

    always_comb begin
        case (lsu_size_i)
            LDST_B, LDST_BU: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_d    = 4'b0011 << lsu_addr_i[1:0];
                wdata_d = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_data_i;
            end
        endcase
    end

    miriscv_lsu_ext u_ext (
        .rdata  (data_rdata_i),
        .size   (size_q),
        .offset (offset_q),
        .result (ext_result)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0;
            data_addr_o  <= 32'b0;
            data_wdata_o <= 32'b0;
            size_q       <= 3'b0;
            offset_q     <= 2'b0;
            lsu_data_o   <= 32'b0;
            lsu_valid_o  <= 1'b0;
        end else begin
            lsu_valid_o <= 1'b0;
            if (accept) begin
                data_req_o   <= 1'b1;
                data_we_o    <= lsu_we_i;
                data_be_o    <= be_d;
                data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                data_wdata_o <= lsu_we_i ? wdata_d : 32'b0;
                size_q       <= lsu_size_i;
                offset_q     <= lsu_addr_i[1:0];
            end
            if (ack_seen) begin
                data_req_o   <= 1'b0;
                data_we_o    <= 1'b0;
                data_be_o    <= 4'b0;
                data_addr_o  <= 32'b0;
                data_wdata_o <= 32'b0;
                // data_we_o still holds the access direction in this cycle.
                if (!data_we_o) begin
                    lsu_data_o  <= ext_result;
                    lsu_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb/tb_miriscv_lsu.sv - randomized self-checking bench for miriscv_lsu

module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_stall_req_o;
    logic        lsu_misalign_o;
    logic [31:0] lsu_data_o;
    logic        lsu_valid_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_ack_i;

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .reset           (reset),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_data_o      (lsu_data_o),
        .lsu_valid_o     (lsu_valid_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_rdata_i    (data_rdata_i),
        .data_ack_i      (data_ack_i)
    );

    always #5 clk_i = ~clk_i;

    logic        chk_en = 1'b0;
    logic        e_stall, e_mis, e_req, e_we, e_valid;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_data;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall",    {31'b0, lsu_stall_req_o}, {31'b0, e_stall});
            chk("misalign", {31'b0, lsu_misalign_o},  {31'b0, e_mis});
            chk("data_req", {31'b0, data_req_o},      {31'b0, e_req});
            chk("data_we",  {31'b0, data_we_o},       {31'b0, e_we});
            chk("data_be",  {28'b0, data_be_o},       {28'b0, e_be});
            chk("addr",     data_addr_o,              e_addr);
            chk("wdata",    data_wdata_o,             e_wdata);
            chk("valid",    {31'b0, lsu_valid_o},     {31'b0, e_valid});
            chk("lsu_data", lsu_data_o,               e_data);
        end
    end

    // ---------------- reference model (byte-level view of an access) ----------------
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] s, input logic [1:0] off);
        logic [3:0] be;
        int n = nbytes(s);
        for (int i = 0; i < 4; i++)
            be[i] = (i >= int'(off)) && (i < int'(off) + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] d);
        logic [31:0] w;
        int n = nbytes(s);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [2:0] s, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> (8 * int'(off));
        h = rd >> (16 * int'(off[1]));
        case (s)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd4:    return {24'b0, b[7:0]};
            3'd1:    return {{16{h[15]}}, h[15:0]};
            3'd5:    return {16'b0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_exp();
        e_stall = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_we = 1'b0;
        e_be = 4'b0; e_addr = 32'b0; e_wdata = 32'b0; e_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        step();
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'($urandom);
        lsu_size_i   = 3'($urandom_range(0, 7));
        lsu_addr_i   = $urandom;
        lsu_data_i   = $urandom;
        data_ack_i   = 1'($urandom);
        data_rdata_i = $urandom;
        idle_exp();
    endtask

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] rdata, input int delay,
                          input logic use_lit, input logic [31:0] lit_addr,
                          input logic [3:0] lit_be, input logic [31:0] lit_wdata,
                          input logic [31:0] lit_data);
        int   n;
        logic legal;
        n     = nbytes(sz);
        legal = (n != 0) && ((int'(addr[1:0]) % n) == 0);
        step();
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_size_i   = sz;
        lsu_addr_i   = addr;
        lsu_data_i   = d;
        data_ack_i   = 1'($urandom);
        data_rdata_i = $urandom;
        idle_exp();
        if (!legal) begin
            e_mis = 1'b1;
            if (use_lit) begin
                @(negedge clk_i);
                chk("lit_misalign", {31'b0, lsu_misalign_o}, 32'd1);
                chk("lit_mis_stall", {31'b0, lsu_stall_req_o}, 32'd0);
            end
            return;
        end
        e_stall = 1'b1;
        for (int i = 0; i <= delay; i++) begin
            step();
            data_ack_i   = (i == delay);
            data_rdata_i = (i == delay) ? rdata : $urandom;
            e_stall = 1'b1; e_mis = 1'b0; e_req = 1'b1; e_we = we;
            e_be    = m_be(sz, addr[1:0]);
            e_addr  = {addr[31:2], 2'b00};
            e_wdata = we ? m_wdata(sz, d) : 32'b0;
            e_valid = 1'b0;
            if (use_lit && i == 0) begin
                @(negedge clk_i);
                chk("lit_addr",  data_addr_o,  lit_addr);
                chk("lit_be",    {28'b0, data_be_o}, {28'b0, lit_be});
                chk("lit_wdata", data_wdata_o, lit_wdata);
            end
        end
        // DONE cycle: any new request shown here must be ignored
        step();
        data_ack_i   = 1'b0;
        data_rdata_i = $urandom;
        lsu_req_i    = 1'($urandom);
        lsu_we_i     = 1'($urandom);
        lsu_size_i   = 3'($urandom_range(0, 7));
        lsu_addr_i   = $urandom;
        idle_exp();
        if (!we) begin
            e_valid = 1'b1;
            e_data  = m_ext(rdata, sz, addr[1:0]);
        end
        if (use_lit) begin
            @(negedge clk_i);
            chk("lit_data", lsu_data_o, lit_data);
        end
    endtask

    initial begin
        reset = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
        lsu_addr_i = 32'b0; lsu_data_i = 32'b0; data_rdata_i = 32'b0; data_ack_i = 1'b0;
        step();
        idle_exp();
        e_data = 32'b0;
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // directed cases
        access(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1'b1, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1'b1, 32'h1000, 4'b1000, 32'h0, 32'h0000_0080);
        access(1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1, 1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
        access(1'b0, 3'd2, 32'h0000_1002, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
        idle_cycle();
        access(1'b0, 3'd3, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
        idle_cycle();
        access(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 32'h40, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        access(1'b0, 3'd1, 32'h0000_0010, 32'h0, 32'h1234_F00D, 0, 1'b1, 32'h10, 4'b0011, 32'h0, 32'hFFFF_F00D);
        access(1'b0, 3'd5, 32'h0000_0012, 32'h0, 32'h1234_F00D, 2, 1'b1, 32'h10, 4'b1100, 32'h0, 32'h0000_1234);

        // randomized traffic, back-to-back and with gaps
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 4)), 1'b0, 32'h0, 4'b0, 32'h0, 32'h0);
        end

        // reset while waiting for the bus, late ack afterwards
        step();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h0000_0080;
        data_ack_i = 1'b0;
        idle_exp(); e_stall = 1'b1;
        step();
        e_stall = 1'b1; e_req = 1'b1; e_be = 4'b1111; e_addr = 32'h80;
        step();
        reset = 1'b1; lsu_req_i = 1'b0;
        e_stall = 1'b0;
        step();
        reset = 1'b0;
        idle_exp(); e_data = 32'b0;
        step();
        data_ack_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        step();
        data_ack_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid", {31'b0, lsu_valid_o}, 32'd0);
        chk("rst_data", lsu_data_o, 32'd0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) idle_cycle();
            access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), 1'b0, 32'h0, 4'b0, 32'h0, 32'h0);
        end
        idle_cycle();
        @(negedge clk_i);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
